// File: rtl/bus_pkg.sv
// Shared types for the bus line access unit: bus phase, controller state,
// and word/line containers.
package bus_pkg;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_SETUP,
      PH_ACCESS
   } bus_phase_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } bau_state_e;

   typedef logic [31:0] word_t;

   // Default line geometry; parametrised instances size their own line arrays.
   localparam int unsigned LINE_WORDS_DEFAULT = 8;
   typedef word_t [LINE_WORDS_DEFAULT-1:0] line_t;

endpackage

// File: rtl/bus_line_access_unit_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and wraps around
// modulo CHANNEL_COUNT.
module rr_arbiter
   import bus_pkg::*;
#(
   parameter int unsigned CHANNEL_COUNT = 2,
   localparam int unsigned IW = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
   input  logic [CHANNEL_COUNT-1:0] req,
   input  logic [IW-1:0]            ptr,
   output logic [CHANNEL_COUNT-1:0] onehot,
   output logic [IW-1:0]            index,
   output logic                     any
);

   always_comb begin
      int unsigned c;
      onehot = '0;
      index  = '0;
      any    = 1'b0;
      c      = 0;
      for (int unsigned i = 0; i < CHANNEL_COUNT; i++) begin
         c = (32'(ptr) + i) % CHANNEL_COUNT;
         if (!any && req[c]) begin
            any       = 1'b1;
            index     = IW'(c);
            onehot[c] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_line_access_unit.sv
// Bus master: arbitrates client line/single-word requests and runs them as
// Setup/Access beats on an APB-style bus, aborting a stalled beat on timeout.
module bus_line_access_unit
   import bus_pkg::*;
#(
   parameter int unsigned CHANNEL_COUNT  = 2,
   parameter int unsigned LINE_WORDS     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [CHANNEL_COUNT-1:0]                 req_valid,
   input  logic [CHANNEL_COUNT-1:0]                 req_write,
   input  logic [CHANNEL_COUNT-1:0]                 req_single,
   input  logic [CHANNEL_COUNT-1:0][31:0]           req_addr,
   input  logic [CHANNEL_COUNT-1:0][LINE_WORDS*32-1:0] req_wdata,
   output logic [CHANNEL_COUNT-1:0]                 grant,
   output logic                                     resp_error,
   output logic [LINE_WORDS*32-1:0]                 resp_rdata,
   output logic [31:0]                              addr,
   output logic                                     select,
   output logic                                     enable,
   output logic                                     write,
   output logic [31:0]                              wdata,
   input  logic [31:0]                              rdata,
   input  logic                                     ready
);

   localparam int unsigned IW = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;
   localparam int unsigned WI = $clog2(LINE_WORDS);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   bau_state_e               state;
   bus_phase_e               phase;
   logic [IW-1:0]            ptr;
   logic [IW-1:0]            win_index;
   logic [CHANNEL_COUNT-1:0] win_onehot;
   logic                     win_any;
   logic [CHANNEL_COUNT-1:0] lgrant;
   logic                     lwrite;
   logic                     lsingle;
   word_t                    laddr;
   word_t [LINE_WORDS-1:0]   lwdata;
   word_t [LINE_WORDS-1:0]   rline;
   logic [WI-1:0]            idx;
   logic [WI-1:0]            next_idx;
   logic [TW-1:0]            tcnt;
   logic                     last_beat;
   logic                     timed_out;

   rr_arbiter #(
      .CHANNEL_COUNT(CHANNEL_COUNT)
   ) u_arb (
      .req    (req_valid),
      .ptr    (ptr),
      .onehot (win_onehot),
      .index  (win_index),
      .any    (win_any)
   );

   function automatic word_t beat_addr(input word_t base, input logic [WI-1:0] i,
                                       input logic single);
      word_t mask;
      mask = word_t'((LINE_WORDS * 4) - 1);
      return single ? (base & ~word_t'(3)) : ((base & ~mask) | (word_t'(i) << 2));
   endfunction

   assign next_idx   = idx + 1'b1;
   assign last_beat  = lsingle || (idx == WI'(LINE_WORDS - 1));
   assign timed_out  = (tcnt == TW'(TIMEOUT_CYCLES - 1));
   assign resp_rdata = rline;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         phase      <= PH_IDLE;
         ptr        <= '0;
         lgrant     <= '0;
         lwrite     <= 1'b0;
         lsingle    <= 1'b0;
         laddr      <= '0;
         lwdata     <= '0;
         rline      <= '0;
         idx        <= '0;
         tcnt       <= '0;
         grant      <= '0;
         resp_error <= 1'b0;
         addr       <= '0;
         select     <= 1'b0;
         enable     <= 1'b0;
         write      <= 1'b0;
         wdata      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (win_any) begin
                  state   <= ST_BUSY;
                  phase   <= PH_SETUP;
                  lgrant  <= win_onehot;
                  lwrite  <= req_write[win_index];
                  lsingle <= req_single[win_index];
                  laddr   <= req_addr[win_index];
                  lwdata  <= req_wdata[win_index];
                  ptr     <= (win_index == IW'(CHANNEL_COUNT - 1)) ? '0 : win_index + 1'b1;
                  idx     <= '0;
                  tcnt    <= '0;
                  rline   <= '0;
                  select  <= 1'b1;
                  enable  <= 1'b0;
                  write   <= 1'b0;
                  addr    <= beat_addr(req_addr[win_index], '0, req_single[win_index]);
                  wdata   <= req_wdata[win_index][31:0];
               end
            end
            ST_BUSY: begin
               case (phase)
                  PH_SETUP: begin
                     phase  <= PH_ACCESS;
                     enable <= 1'b1;
                     write  <= lwrite;
                     tcnt   <= '0;
                  end
                  PH_ACCESS: begin
                     if (ready && !lwrite) rline[idx] <= rdata;
                     // ready takes priority over a timeout landing on the same cycle
                     if ((ready && last_beat) || (!ready && timed_out)) begin
                        state      <= ST_DONE;
                        phase      <= PH_IDLE;
                        select     <= 1'b0;
                        enable     <= 1'b0;
                        write      <= 1'b0;
                        addr       <= '0;
                        wdata      <= '0;
                        idx        <= '0;
                        grant      <= lgrant;
                        resp_error <= !ready;
                     end else if (ready) begin
                        idx    <= next_idx;
                        phase  <= PH_SETUP;
                        enable <= 1'b0;
                        write  <= 1'b0;
                        addr   <= beat_addr(laddr, next_idx, lsingle);
                        wdata  <= lwdata[next_idx];
                     end else begin
                        tcnt <= tcnt + 1'b1;
                     end
                  end
                  default: phase <= PH_IDLE;
               endcase
            end
            ST_DONE: begin
               state      <= ST_IDLE;
               grant      <= '0;
               resp_error <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/bus_line_access_unit.md
Name: bus_line_access_unit

Overview:
Next-generation bus master between the cache/IO clients and the external APB-style bus. It takes line or single-word read/write requests from CHANNEL_COUNT clients and picks one with round-robin arbitration. It transfers the request as LINE_WORDS back-to-back bus beats with no idle cycle between words. A bus transfer that stalls past TIMEOUT_CYCLES is aborted and reported to the client as an error.

Parameters:
CHANNEL_COUNT, 2, number of requesting clients; must be at least 1.
LINE_WORDS, 8, 32-bit words per line transfer; must be a power of 2 and at least 2.
TIMEOUT_CYCLES, 255, maximum Access cycles per beat before abort; must be at least 1.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
req_valid  in  CHANNEL_COUNT  request per channel; held until that channel's grant
req_write  in  CHANNEL_COUNT  1 = write, 0 = read
req_single  in  CHANNEL_COUNT  1 = single-word (uncached IO) access, 0 = full line
req_addr  in  CHANNEL_COUNT x 32  byte address per channel
req_wdata  in  CHANNEL_COUNT x LINE_WORDS*32  write data; word 0 holds the single-word data
grant  out  CHANNEL_COUNT  one-cycle completion pulse, one-hot
resp_error  out  1  valid with grant; 1 = timeout abort
resp_rdata  out  LINE_WORDS*32  read line; valid with grant, held until the next accept
addr  out  32  bus address
select  out  1  bus select
enable  out  1  bus enable (Access phase)
write  out  1  bus write strobe
wdata  out  32  bus write data
rdata  in  32  bus read data
ready  in  1  bus completion, sampled in Access

Behaviour:
- Reset: clk and rst are the only clock and reset; rst is asynchronous and active-high.
  - rst clears state to Idle, the bus phase to Idle, the round-robin pointer to 0, all counters, and all data registers.
  - All outputs are 0 while rst is high. select and enable drop immediately on rst, even mid-transfer; no grant is issued for the aborted request.
- Main FSM states: Idle, Busy, Done.
  - Idle: if any req_valid bit is set, latch the winner's index, write, single, addr and wdata, then go to Busy. Otherwise stay in Idle.
  - Busy: runs the beats. After the last beat's ready, or after a timeout, go to Done.
  - Done: grant[winner] = 1 for exactly one cycle, with resp_error and resp_rdata valid; then go to Idle. Requests are therefore never accepted back to back: there is always at least one Idle cycle.
- Arbitration:
  - Round-robin. Search starts at ptr and wraps modulo CHANNEL_COUNT.
  - On accept, ptr becomes winner+1, wrapping to 0 after CHANNEL_COUNT-1.
  - Only the latched copy of the request is used after accept; later changes on the request inputs are ignored.
- Bus phase within Busy:
  - First cycle of Busy is Setup: select=1, enable=0.
  - Next cycle is Access: select=1, enable=1.
  - In Access with ready=1: capture rdata into word[idx] on reads. If this was the last beat, go to Done; otherwise increment idx and go straight to Setup.
  - In Access with ready=0: stay in Access and increment the timeout counter.
- Addressing and data:
  - Line access: addr = {latched_addr[31:log2(LINE_WORDS)+2], idx, 2'b00}. idx runs from 0 to LINE_WORDS-1 and wraps to 0 at the end.
  - Single access: addr = {latched_addr[31:2], 2'b00}, one beat only. Read data lands in word 0; other words read as 0.
  - write = enable AND latched write.
  - wdata = latched word[idx] during Setup and Access, 0 otherwise.
  - In Idle and Done: addr = 0 and wdata = 0.
- Timeout:
  - The counter resets on every Setup.
  - If the counter reaches TIMEOUT_CYCLES while ready=0, drop select and enable and go to Done with resp_error=1.
  - Words already read are kept; the remaining words are 0.
  - ready and the timeout arriving on the same cycle: ready wins and no error is reported.
- Timing: with zero wait states, latency from accept to grant is 2*beats+1 cycles (8-word line: grant 17 cycles after the accept cycle).

Decomposition:
- Shared package bus_pkg holds:
  - the BusPhase enum (Idle, Setup, Access)
  - the BauState enum (Idle, Busy, Done)
  - a word_t typedef (32 bits)
  - a line_t typedef (LINE_WORDS words)
- One sub-module, rr_arbiter, parametrised by CHANNEL_COUNT:
  - inputs: req vector, ptr
  - outputs: one-hot winner, winner index, any
  - purely combinational

Test Plan:
1. Reset mid-line: raise rst during Access of beat 3 -> select and enable go to 0 immediately; after release, state is Idle, no grant, ptr = 0.
2. Single read: ch0 req_single=1, addr 0x1000_0006, ready=1 every Access -> one Setup/Access at addr 0x1000_0004; grant[0] 3 cycles after accept; resp_rdata word 0 = rdata, other words 0.
3. Line write: ch1 line write at 0x2000_0040 (LINE_WORDS=8), no waits -> addrs 0x...40, 44, ... 5C with wdata = words 0..7; write high only with enable; grant[1] at accept+17.
4. Arbitration: ch0 and ch1 both request continuously -> grants alternate 0, 1, 0, 1 with at least one Idle cycle between them.
5. Timeout: TIMEOUT_CYCLES=4, ready held 0 on beat 2 of a line read -> abort after 4 Access cycles; grant with resp_error=1; words 0-1 valid, the rest 0.
6. Ready on the timeout boundary: ready=1 on the same cycle the counter reaches 4 -> no error, transfer continues.
